valu_seq: RTL and testbench

- Issue/sequencing controller for the 64-bit vector ALU.
- Accepts one vector arithmetic/logic instruction at a time over a valid/ready handshake.
- Walks the destination register group (LMUL = 1/2/4/8). For each register it reads the source vector registers from the VRF, drives the vALU, and writes the result back.
- Sits between the vector decode stage and the VRF/vALU pair. It is the only VRF writer while busy.

---
 rtl/valu_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_valu_seq.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/valu_seq.sv
// valu_seq: issue/sequencing controller for the 64-bit vector ALU.
// Accepts one vector instruction over valid/ready, checks it for legality,
// then walks the destination register group one register at a time:
// read both sources (RD), drive the vALU and capture its result (EX),
// write the captured result back to the VRF (WB).
// While an instruction is in flight this block is the only VRF writer.

module valu_seq #(
    parameter int VLEN = 64,
    parameter int NREG = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [2:0]      in_sew,
    input  logic [1:0]      in_lmul,
    input  logic [RA_W-1:0] in_vs1,
    input  logic [RA_W-1:0] in_vs2,
    input  logic [RA_W-1:0] in_vd,
    input  logic [VLEN-1:0] in_scalar,

    output logic [RA_W-1:0] vrf_raddr1,
    output logic [RA_W-1:0] vrf_raddr2,
    input  logic [VLEN-1:0] vrf_rdata1,
    input  logic [VLEN-1:0] vrf_rdata2,
    output logic            vrf_we,
    output logic [RA_W-1:0] vrf_waddr,
    output logic [VLEN-1:0] vrf_wdata,

    output logic [3:0]      valu_op,
    output logic [2:0]      valu_sew,
    output logic [VLEN-1:0] valu_in1,
    output logic [VLEN-1:0] valu_in2,
    output logic [VLEN-1:0] valu_scalar,
    input  logic [VLEN-1:0] valu_result,

    output logic            busy,
    output logic            done,
    output logic            illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        EX   = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched instruction fields, valid from the accept edge onwards
    logic [3:0]      op_q;
    logic [2:0]      sew_q;
    logic [1:0]      lmul_q;
    logic [RA_W-1:0] vs1_q;
    logic [RA_W-1:0] vs2_q;
    logic [RA_W-1:0] vd_q;
    logic [VLEN-1:0] scalar_q;

    // Register index within the group (0..G-1), G is at most 8
    logic [2:0]      regIdx_q, regIdx_d;

    // vALU result captured at the end of EX and presented during WB
    logic [VLEN-1:0] wdata_q;

    // One-cycle rejection pulse, raised the cycle after a bad accept
    logic            illegal_q;

    logic            accept;
    logic [3:0]      grpSize;
    logic [RA_W-1:0] grpMaskRa;
    logic [RA_W+1:0] vdEnd;
    logic            opLegal;
    logic            sewLegal;
    logic            alignedOk;
    logic            fitsOk;
    logic            instrLegal;
    logic [2:0]      lastIdx;
    logic            lastReg;

    assign accept = in_valid && in_ready;

    // Legality of the instruction currently offered on the input port.
    // Alignment to G guarantees source and destination groups are either
    // identical or disjoint, which is what makes in-place operation safe.
    always_comb begin
        grpSize    = 4'd1 << in_lmul;
        grpMaskRa  = RA_W'(grpSize - 4'd1);
        vdEnd      = {2'b00, in_vd} + (RA_W+2)'(grpSize);
        opLegal    = (in_op <= 4'hB);
        sewLegal   = (in_sew <= 3'd3);
        alignedOk  = ((in_vs1 & grpMaskRa) == '0) &&
                     ((in_vs2 & grpMaskRa) == '0) &&
                     ((in_vd  & grpMaskRa) == '0);
        fitsOk     = (vdEnd <= (RA_W+2)'(NREG));
        instrLegal = opLegal && sewLegal && alignedOk && fitsOk;
    end

    // Last register of the group is index G-1 of the latched group size
    always_comb begin
        lastIdx = 3'((4'd1 << lmul_q) - 4'd1);
        lastReg = (regIdx_q == lastIdx);
    end

    // State register; reset aborts any instruction in flight immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            regIdx_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            regIdx_q <= regIdx_d;
        end
    end

    // Next-state and register-index sequencing: RD -> EX -> WB per register
    always_comb begin
        state_d  = state_q;
        regIdx_d = regIdx_q;
        case (state_q)
            IDLE: begin
                regIdx_d = 3'd0;
                if (accept && instrLegal) begin
                    state_d = RD;
                end
            end
            RD: begin
                state_d = EX;
            end
            EX: begin
                state_d = WB;
            end
            WB: begin
                if (lastReg) begin
                    state_d  = IDLE;
                    regIdx_d = 3'd0;
                end else begin
                    state_d  = RD;
                    regIdx_d = regIdx_q + 3'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                regIdx_d = 3'd0;
            end
        endcase
    end

    // Instruction capture on accept; fields are only ever used while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= 4'd0;
            sew_q    <= 3'd0;
            lmul_q   <= 2'd0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
            scalar_q <= '0;
        end else if (accept) begin
            op_q     <= in_op;
            sew_q    <= in_sew;
            lmul_q   <= in_lmul;
            vs1_q    <= in_vs1;
            vs2_q    <= in_vs2;
            vd_q     <= in_vd;
            scalar_q <= in_scalar;
        end
    end

    // Result capture at the end of EX, plus the rejection pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (state_q == EX) begin
                wdata_q <= valu_result;
            end
            illegal_q <= accept && !instrLegal;
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        vrf_raddr1  = '0;
        vrf_raddr2  = '0;
        vrf_we      = 1'b0;
        vrf_waddr   = '0;
        valu_op     = 4'd0;
        valu_sew    = 3'd0;
        valu_in1    = '0;
        valu_in2    = '0;
        valu_scalar = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            RD: begin
                busy        = 1'b1;
                valu_op     = op_q;
                valu_sew    = sew_q;
                valu_scalar = scalar_q;
                vrf_raddr1  = vs1_q + RA_W'(regIdx_q);
                vrf_raddr2  = vs2_q + RA_W'(regIdx_q);
            end
            EX: begin
                busy        = 1'b1;
                valu_op     = op_q;
                valu_sew    = sew_q;
                valu_scalar = scalar_q;
                valu_in1    = vrf_rdata1;
                valu_in2    = vrf_rdata2;
            end
            WB: begin
                busy        = 1'b1;
                valu_op     = op_q;
                valu_sew    = sew_q;
                valu_scalar = scalar_q;
                vrf_we      = 1'b1;
                vrf_waddr   = vd_q + RA_W'(regIdx_q);
                done        = lastReg;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign vrf_wdata = wdata_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_valu_seq.sv
// tb_valu_seq: bench for the vALU sequencing controller.
// Provides a behavioural VRF and vALU around the controller, logs every
// handshake, write, done and illegal event from a negedge monitor, and
// compares against expectations derived from the instruction semantics.

module tb_valu_seq;

    localparam int VLEN = 64;
    localparam int NREG = 32;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [2:0]      in_sew;
    logic [1:0]      in_lmul;
    logic [RA_W-1:0] in_vs1, in_vs2, in_vd;
    logic [VLEN-1:0] in_scalar;
    logic [RA_W-1:0] vrf_raddr1, vrf_raddr2;
    logic [VLEN-1:0] vrf_rdata1, vrf_rdata2;
    logic            vrf_we;
    logic [RA_W-1:0] vrf_waddr;
    logic [VLEN-1:0] vrf_wdata;
    logic [3:0]      valu_op;
    logic [2:0]      valu_sew;
    logic [VLEN-1:0] valu_in1, valu_in2, valu_scalar, valu_result;
    logic            busy, done, illegal;

    int tests = 0;
    int fails = 0;
    int sendTimeouts = 0;
    int idleTimeouts = 0;

    logic [63:0] vrf     [NREG];
    logic [63:0] image   [NREG];
    logic [63:0] refRegs [NREG];
    logic        loadReq = 1'b0;

    int          cyc = 0;
    int          accCyc[$];
    int          wrCyc[$];
    int          wrAddr[$];
    logic [63:0] wrData[$];
    int          doneCyc[$];
    int          illCyc[$];
    int          readyRise[$];
    int          notReadyCnt = 0;
    logic        prevReady = 1'b1;

    int          expAddr[$];
    logic [63:0] expData[$];

    always #5 clk = ~clk;

    valu_seq #(.VLEN(VLEN), .NREG(NREG), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_sew(in_sew), .in_lmul(in_lmul),
        .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vd(in_vd),
        .in_scalar(in_scalar),
        .vrf_raddr1(vrf_raddr1), .vrf_raddr2(vrf_raddr2),
        .vrf_rdata1(vrf_rdata1), .vrf_rdata2(vrf_rdata2),
        .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
        .valu_op(valu_op), .valu_sew(valu_sew),
        .valu_in1(valu_in1), .valu_in2(valu_in2), .valu_scalar(valu_scalar),
        .valu_result(valu_result),
        .busy(busy), .done(done), .illegal(illegal)
    );

    // Lane-wise vALU: even codes are vector-vector, odd codes use the scalar
    function automatic logic [63:0] aluRef(input logic [3:0] op, input logic [2:0] sew,
                                           input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] s);
        int w;
        logic [63:0] mask, x, y, sc, r, res;
        if (sew > 3'd3) return 64'd0;
        w = 8 << sew;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        sc = s & mask;
        res = 64'd0;
        for (int i = 0; i < 64 / w; i++) begin
            x = (a >> (i * w)) & mask;
            y = (b >> (i * w)) & mask;
            case (op)
                4'h0: r = x + y;
                4'h1: r = y + sc;
                4'h2: r = y - x;
                4'h3: r = y - sc;
                4'h4: r = x * y;
                4'h5: r = y * sc;
                4'h6: r = x & y;
                4'h7: r = y & sc;
                4'h8: r = x | y;
                4'h9: r = y | sc;
                4'hA: r = x ^ y;
                4'hB: r = y ^ sc;
                default: r = 64'd0;
            endcase
            res = res | ((r & mask) << (i * w));
        end
        return res;
    endfunction

    assign valu_result = aluRef(valu_op, valu_sew, valu_in1, valu_in2, valu_scalar);

    // Behavioural VRF: one-cycle read latency, single-cycle write, bulk preload
    always @(posedge clk) begin
        if (loadReq) begin
            for (int i = 0; i < NREG; i++) vrf[i] <= image[i];
        end else if (vrf_we) begin
            vrf[vrf_waddr] <= vrf_wdata;
        end
        vrf_rdata1 <= vrf[vrf_raddr1];
        vrf_rdata2 <= vrf[vrf_raddr2];
    end

    // Cycle counter: value k means k rising edges have passed
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled mid-cycle
    always @(negedge clk) begin
        if (in_valid && in_ready && !rst) accCyc.push_back(cyc);
        if (vrf_we) begin
            wrCyc.push_back(cyc);
            wrAddr.push_back(int'(vrf_waddr));
            wrData.push_back(vrf_wdata);
        end
        if (done) doneCyc.push_back(cyc);
        if (illegal) illCyc.push_back(cyc);
        if (in_ready && !prevReady) readyRise.push_back(cyc);
        if (!in_ready) notReadyCnt <= notReadyCnt + 1;
        prevReady <= in_ready;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic loadRegs();
        loadReq = 1'b1;
        @(posedge clk); #1;
        loadReq = 1'b0;
        for (int i = 0; i < NREG; i++) refRegs[i] = image[i];
    endtask

    task automatic randomImage();
        for (int i = 0; i < NREG; i++) image[i] = {$urandom(), $urandom()};
    endtask

    task automatic sendInstr(input logic [3:0] op, input logic [2:0] sew, input logic [1:0] lmul,
                             input int v1, input int v2, input int d, input logic [63:0] sc);
        int n;
        in_op = op; in_sew = sew; in_lmul = lmul;
        in_vs1 = RA_W'(v1); in_vs2 = RA_W'(v2); in_vd = RA_W'(d);
        in_scalar = sc;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) sendTimeouts++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!(in_ready && !busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(in_ready && !busy)) idleTimeouts++;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Reference: instruction semantics over a snapshot of the register file
    task automatic modelInstr(input logic [3:0] op, input logic [2:0] sew, input logic [1:0] lmul,
                              input int v1, input int v2, input int d, input logic [63:0] sc,
                              output bit legal, output int g);
        logic [63:0] snap [NREG];
        g = 1 << lmul;
        legal = (op <= 4'hB) && (sew <= 3'd3) && (v1 % g == 0) && (v2 % g == 0) &&
                (d % g == 0) && (d + g <= NREG);
        expAddr.delete();
        expData.delete();
        if (legal) begin
            snap = refRegs;
            for (int k = 0; k < g; k++) begin
                expAddr.push_back(d + k);
                expData.push_back(aluRef(op, sew, snap[v1 + k], snap[v2 + k], sc));
                refRegs[d + k] = aluRef(op, sew, snap[v1 + k], snap[v2 + k], sc);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests++; if ({done, illegal, vrf_we} !== 3'b000) begin fails++; $display("[TB] FAIL reset_pulses: got %b expected 000", {done, illegal, vrf_we}); end
        tests++; if ({vrf_raddr1, vrf_raddr2, vrf_waddr} !== 15'd0) begin fails++; $display("[TB] FAIL reset_addr: got %h expected 0", {vrf_raddr1, vrf_raddr2, vrf_waddr}); end
        tests++; if ({valu_op, valu_sew} !== 7'd0) begin fails++; $display("[TB] FAIL reset_opsew: got %h expected 0", {valu_op, valu_sew}); end
        tests++; if ({vrf_wdata, valu_scalar} !== 128'd0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 0", {vrf_wdata, valu_scalar}); end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_release: ready %b busy %b expected 1 0", in_ready, busy); end
    endtask

    task automatic test_single();
        int ab, wb, db, rb;
        randomImage();
        image[1] = 64'h0101010101010101;
        image[2] = 64'h0202020202020202;
        loadRegs();
        ab = accCyc.size(); wb = wrCyc.size(); db = doneCyc.size(); rb = readyRise.size();
        sendInstr(4'h0, 3'd0, 2'd0, 1, 2, 3, 64'd0);
        waitIdle();
        tests++;
        if (wrCyc.size() - wb != 1 || accCyc.size() - ab != 1) begin
            fails++; $display("[TB] FAIL single_count: writes %0d accepts %0d expected 1 1", wrCyc.size() - wb, accCyc.size() - ab);
        end else begin
            tests++; if (wrCyc[wb] - accCyc[ab] != 3) begin fails++; $display("[TB] FAIL single_wcycle: got %0d expected 3", wrCyc[wb] - accCyc[ab]); end
            tests++; if (wrAddr[wb] != 3) begin fails++; $display("[TB] FAIL single_waddr: got %0d expected 3", wrAddr[wb]); end
            tests++; if (wrData[wb] !== 64'h0303030303030303) begin fails++; $display("[TB] FAIL single_wdata: got %h expected 0303030303030303", wrData[wb]); end
            tests++;
            if (doneCyc.size() - db != 1) begin fails++; $display("[TB] FAIL single_done: got %0d pulses expected 1", doneCyc.size() - db); end
            else if (doneCyc[db] - accCyc[ab] != 3) begin fails++; $display("[TB] FAIL single_done: cycle %0d expected 3", doneCyc[db] - accCyc[ab]); end
            tests++;
            if (readyRise.size() - rb < 1) begin fails++; $display("[TB] FAIL single_ready: no rise seen expected cycle 4"); end
            else if (readyRise[rb] - accCyc[ab] != 4) begin fails++; $display("[TB] FAIL single_ready: cycle %0d expected 4", readyRise[rb] - accCyc[ab]); end
        end
    endtask

    task automatic test_group();
        int ab, wb, db;
        logic [63:0] src, expv;
        randomImage();
        loadRegs();
        ab = accCyc.size(); wb = wrCyc.size(); db = doneCyc.size();
        sendInstr(4'h1, 3'd1, 2'd2, 16, 8, 12, 64'h0001);
        waitIdle();
        tests++;
        if (wrCyc.size() - wb != 4) begin
            fails++; $display("[TB] FAIL group_count: got %0d writes expected 4", wrCyc.size() - wb);
        end else begin
            for (int k = 0; k < 4; k++) begin
                src = image[8 + k];
                for (int l = 0; l < 4; l++) expv[l*16 +: 16] = src[l*16 +: 16] + 16'd1;
                tests++; if (wrAddr[wb+k] != 12 + k) begin fails++; $display("[TB] FAIL group_waddr%0d: got %0d expected %0d", k, wrAddr[wb+k], 12 + k); end
                tests++; if (wrData[wb+k] !== expv) begin fails++; $display("[TB] FAIL group_wdata%0d: got %h expected %h", k, wrData[wb+k], expv); end
                tests++; if (wrCyc[wb+k] - accCyc[ab] != 3 * (k + 1)) begin fails++; $display("[TB] FAIL group_wcycle%0d: got %0d expected %0d", k, wrCyc[wb+k] - accCyc[ab], 3 * (k + 1)); end
                tests++; if (vrf[12 + k] !== expv) begin fails++; $display("[TB] FAIL group_reg%0d: got %h expected %h", k, vrf[12 + k], expv); end
            end
        end
        tests++;
        if (doneCyc.size() - db != 1) begin fails++; $display("[TB] FAIL group_done: got %0d pulses expected 1", doneCyc.size() - db); end
        else if (doneCyc[db] - accCyc[ab] != 12) begin fails++; $display("[TB] FAIL group_done: cycle %0d expected 12", doneCyc[db] - accCyc[ab]); end
    endtask

    task automatic test_inplace();
        int wb;
        randomImage();
        image[4] = 64'h0000000300000002;
        image[5] = 64'h0000000500000007;
        loadRegs();
        wb = wrCyc.size();
        sendInstr(4'h4, 3'd2, 2'd1, 4, 4, 4, 64'd0);
        waitIdle();
        tests++; if (wrCyc.size() - wb != 2) begin fails++; $display("[TB] FAIL inplace_count: got %0d writes expected 2", wrCyc.size() - wb); end
        tests++; if (vrf[4] !== 64'h0000000900000004) begin fails++; $display("[TB] FAIL inplace_reg4: got %h expected 0000000900000004", vrf[4]); end
        tests++; if (vrf[5] !== 64'h0000001900000031) begin fails++; $display("[TB] FAIL inplace_reg5: got %h expected 0000001900000031", vrf[5]); end
    endtask

    task automatic test_illegal();
        int ab, wb, ib, nb;
        ab = accCyc.size(); wb = wrCyc.size(); ib = illCyc.size(); nb = notReadyCnt;
        sendInstr(4'h0, 3'd5, 2'd0, 0, 1, 2, 64'd0);
        waitIdle();
        sendInstr(4'h0, 3'd0, 2'd1, 0, 2, 3, 64'd0);
        waitIdle();
        sendInstr(4'hC, 3'd0, 2'd0, 1, 2, 3, 64'd0);
        waitIdle();
        tests++; if (wrCyc.size() - wb != 0) begin fails++; $display("[TB] FAIL illegal_writes: got %0d expected 0", wrCyc.size() - wb); end
        tests++; if (notReadyCnt - nb != 0) begin fails++; $display("[TB] FAIL illegal_ready: in_ready low for %0d cycles expected 0", notReadyCnt - nb); end
        tests++;
        if (illCyc.size() - ib != 3 || accCyc.size() - ab != 3) begin
            fails++; $display("[TB] FAIL illegal_pulses: got %0d pulses %0d accepts expected 3 3", illCyc.size() - ib, accCyc.size() - ab);
        end else begin
            for (int j = 0; j < 3; j++) begin
                tests++; if (illCyc[ib+j] - accCyc[ab+j] != 1) begin fails++; $display("[TB] FAIL illegal_cycle%0d: got %0d expected 1", j, illCyc[ib+j] - accCyc[ab+j]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ab, wb, db, n;
        logic [63:0] resA, resB;
        randomImage();
        loadRegs();
        resA = image[1] + image[2];
        resB = resA ^ image[4];
        ab = accCyc.size(); wb = wrCyc.size(); db = doneCyc.size();
        in_op = 4'h0; in_sew = 3'd3; in_lmul = 2'd0;
        in_vs1 = 5'd1; in_vs2 = 5'd2; in_vd = 5'd3; in_scalar = 64'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_op = 4'hA; in_sew = 3'd0; in_vs1 = 5'd3; in_vs2 = 5'd4; in_vd = 5'd5;
        n = 0;
        while (accCyc.size() < ab + 2 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        waitIdle();
        tests++;
        if (accCyc.size() - ab != 2) begin fails++; $display("[TB] FAIL b2b_accepts: got %0d expected 2", accCyc.size() - ab); end
        else if (accCyc[ab+1] - accCyc[ab] != 4) begin fails++; $display("[TB] FAIL b2b_gap: got %0d expected 4", accCyc[ab+1] - accCyc[ab]); end
        tests++;
        if (wrCyc.size() - wb != 2) begin
            fails++; $display("[TB] FAIL b2b_writes: got %0d expected 2", wrCyc.size() - wb);
        end else begin
            tests++; if (wrAddr[wb] != 3 || wrData[wb] !== resA) begin fails++; $display("[TB] FAIL b2b_first: got %0d/%h expected 3/%h", wrAddr[wb], wrData[wb], resA); end
            tests++; if (wrAddr[wb+1] != 5 || wrData[wb+1] !== resB) begin fails++; $display("[TB] FAIL b2b_second: got %0d/%h expected 5/%h", wrAddr[wb+1], wrData[wb+1], resB); end
            tests++; if (wrCyc[wb+1] - wrCyc[wb] != 4) begin fails++; $display("[TB] FAIL b2b_wspacing: got %0d expected 4", wrCyc[wb+1] - wrCyc[wb]); end
        end
        tests++; if (doneCyc.size() - db != 2) begin fails++; $display("[TB] FAIL b2b_done: got %0d expected 2", doneCyc.size() - db); end
    endtask

    task automatic test_reset_mid();
        int wb;
        logic [63:0] a, b, expv;
        randomImage();
        loadRegs();
        a = image[16]; b = image[20];
        for (int l = 0; l < 8; l++) expv[l*8 +: 8] = a[l*8 +: 8] + b[l*8 +: 8];
        wb = wrCyc.size();
        sendInstr(4'h0, 3'd0, 2'd2, 16, 20, 8, 64'd0);
        repeat (5) begin @(posedge clk); #1; end
        tests++; if (vrf_we !== 1'b1 || vrf_waddr !== 5'd9) begin fails++; $display("[TB] FAIL rstmid_inwb: we %b waddr %0d expected 1 9", vrf_we, vrf_waddr); end
        rst = 1'b1;
        #1;
        tests++; if (vrf_we !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_we: got %b expected 0", vrf_we); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_idle: ready %b busy %b expected 1 0", in_ready, busy); end
        repeat (3) begin @(posedge clk); #1; end
        tests++; if (wrCyc.size() - wb != 1) begin fails++; $display("[TB] FAIL rstmid_writes: got %0d expected 1", wrCyc.size() - wb); end
        tests++; if (vrf[8] !== expv) begin fails++; $display("[TB] FAIL rstmid_reg8: got %h expected %h", vrf[8], expv); end
        for (int r = 9; r < 12; r++) begin
            tests++; if (vrf[r] !== image[r]) begin fails++; $display("[TB] FAIL rstmid_reg%0d: got %h expected %h", r, vrf[r], image[r]); end
        end
    endtask

    task automatic test_random();
        int ab, wb, db, ib, g, v1, v2, d, kind;
        logic [3:0] op;
        logic [2:0] sew;
        logic [1:0] lmul;
        logic [63:0] sc;
        bit legal;
        randomImage();
        loadRegs();
        for (int t = 0; t < 24; t++) begin
            lmul = 2'($urandom_range(0, 3));
            g = 1 << lmul;
            v1 = $urandom_range(0, NREG / g - 1) * g;
            v2 = $urandom_range(0, NREG / g - 1) * g;
            d  = $urandom_range(0, NREG / g - 1) * g;
            op = 4'($urandom_range(0, 11));
            sew = 3'($urandom_range(0, 3));
            sc = {$urandom(), $urandom()};
            kind = $urandom_range(0, 6);
            if (kind == 0) op = 4'($urandom_range(12, 15));
            if (kind == 1) sew = 3'($urandom_range(4, 7));
            if (kind == 2 && g > 1) d = d + 1;
            if (kind == 3) begin v1 = d; v2 = d; end
            modelInstr(op, sew, lmul, v1, v2, d, sc, legal, g);
            ab = accCyc.size(); wb = wrCyc.size(); db = doneCyc.size(); ib = illCyc.size();
            sendInstr(op, sew, lmul, v1, v2, d, sc);
            waitIdle();
            if (legal) begin
                tests++;
                if (wrCyc.size() - wb != g || accCyc.size() - ab != 1) begin
                    fails++; $display("[TB] FAIL rand%0d_count: writes %0d expected %0d", t, wrCyc.size() - wb, g);
                end else begin
                    for (int k = 0; k < g; k++) begin
                        tests++;
                        if (wrAddr[wb+k] != expAddr[k] || wrData[wb+k] !== expData[k] ||
                            wrCyc[wb+k] - accCyc[ab] != 3 * (k + 1)) begin
                            fails++; $display("[TB] FAIL rand%0d_w%0d: got %0d/%h@%0d expected %0d/%h@%0d", t, k,
                                              wrAddr[wb+k], wrData[wb+k], wrCyc[wb+k] - accCyc[ab],
                                              expAddr[k], expData[k], 3 * (k + 1));
                        end
                    end
                    tests++;
                    if (doneCyc.size() - db != 1) begin fails++; $display("[TB] FAIL rand%0d_done: got %0d pulses expected 1", t, doneCyc.size() - db); end
                    else if (doneCyc[db] - accCyc[ab] != 3 * g) begin fails++; $display("[TB] FAIL rand%0d_done: cycle %0d expected %0d", t, doneCyc[db] - accCyc[ab], 3 * g); end
                end
                tests++; if (illCyc.size() - ib != 0) begin fails++; $display("[TB] FAIL rand%0d_illegal: got %0d pulses expected 0", t, illCyc.size() - ib); end
            end else begin
                tests++;
                if (illCyc.size() - ib != 1 || wrCyc.size() - wb != 0) begin
                    fails++; $display("[TB] FAIL rand%0d_reject: pulses %0d writes %0d expected 1 0", t, illCyc.size() - ib, wrCyc.size() - wb);
                end
            end
        end
        for (int r = 0; r < NREG; r++) begin
            tests++; if (vrf[r] !== refRegs[r]) begin fails++; $display("[TB] FAIL rand_final_reg%0d: got %h expected %h", r, vrf[r], refRegs[r]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_op = 4'd0; in_sew = 3'd0; in_lmul = 2'd0;
        in_vs1 = '0; in_vs2 = '0; in_vd = '0; in_scalar = '0;
        for (int i = 0; i < NREG; i++) image[i] = 64'd0;
        test_reset();
        test_single();
        test_group();
        test_inplace();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        tests++;
        if (sendTimeouts + idleTimeouts != 0) begin
            fails++; $display("[TB] FAIL timeouts: got %0d send / %0d idle expected 0 0", sendTimeouts, idleTimeouts);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
